// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter_if
// Brief    : Requester-side push bus and common-data-bus broadcast bundle for
//            the CDB arbiter. The master side is the requesters/consumer, and
//            the slave side is the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int TAG_W   = 3,
   parameter int DATA_W  = 32
);
   logic                        flush;
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ*TAG_W-1:0]    req_tag;
   logic [NUM_REQ*DATA_W-1:0]   req_value;
   logic [NUM_REQ-1:0]          req_ready;
   logic                        cdb_hold;
   logic                        cdb_valid;
   logic [TAG_W-1:0]            cdb_tag;
   logic [DATA_W-1:0]           cdb_value;
   logic [1:0]                  cdb_src;
   logic                        overflow;

   modport master (
      output flush, req_valid, req_tag, req_value, cdb_hold,
      input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, overflow
   );

   modport slave (
      input  flush, req_valid, req_tag, req_value, cdb_hold,
      output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_src, overflow
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Per-requester result FIFOs feeding a round-robin arbiter that
//            drives one registered common-data-bus broadcast per cycle.
//            Flush drops every queued result; hold freezes the broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int TAG_W      = 3,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic      clk,
   input  wire logic      rst,
   cdb_arbiter_if.slave   bus
);

   localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int c_ENT_W = TAG_W + DATA_W;

   logic [NUM_REQ-1:0]  w_ready;
   logic [NUM_REQ-1:0]  w_tag_nz;
   logic [NUM_REQ-1:0]  w_push;
   logic [NUM_REQ-1:0]  w_pop;
   logic [NUM_REQ-1:0]  w_nonempty;
   logic [c_ENT_W-1:0]  w_head [NUM_REQ];

   logic                w_any;
   logic [c_IDX_W-1:0]  w_grant;
   logic [c_IDX_W:0]    w_cand;
   logic [c_IDX_W-1:0]  w_cand_idx;
   logic [c_ENT_W-1:0]  w_win;
   logic                w_ovf_evt;

   logic                r_cdb_valid;
   logic [TAG_W-1:0]    r_cdb_tag;
   logic [DATA_W-1:0]   r_cdb_value;
   logic [1:0]          r_cdb_src;
   logic [c_IDX_W-1:0]  r_last_grant;
   logic                r_overflow;

   // One FIFO per requester. Ready reflects the count before this edge's pop,
   // so a full FIFO never gets same-cycle credit from its own pop.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
      logic [c_PTR_W-1:0] r_wptr;
      logic [c_PTR_W-1:0] r_rptr;
      logic [c_CNT_W-1:0] r_count;

      assign w_tag_nz[i]   = |bus.req_tag[i*TAG_W +: TAG_W];
      assign w_ready[i]    = (r_count < c_CNT_W'(FIFO_DEPTH));
      assign w_nonempty[i] = (r_count != '0);
      assign w_push[i]     = bus.req_valid[i] & w_ready[i] & w_tag_nz[i] & ~bus.flush;
      assign w_pop[i]      = w_any & ~bus.flush & ~bus.cdb_hold & (w_grant == c_IDX_W'(i));
      assign w_head[i]     = r_mem[r_rptr];

      // Entry storage; contents are don't-care while the slot is unoccupied.
      always_ff @(posedge clk) begin
         if (w_push[i]) begin
            r_mem[r_wptr] <= {bus.req_tag[i*TAG_W +: TAG_W], bus.req_value[i*DATA_W +: DATA_W]};
         end
      end

      // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push[i]) r_wptr <= r_wptr + 1'b1;
            if (w_pop[i])  r_rptr <= r_rptr + 1'b1;
            case ({w_push[i], w_pop[i]})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      w_any      = 1'b0;
      w_grant    = r_last_grant;
      w_cand     = '0;
      w_cand_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_last_grant} + (c_IDX_W + 1)'(k + 1);
         if (w_cand >= (c_IDX_W + 1)'(NUM_REQ)) begin
            w_cand = w_cand - (c_IDX_W + 1)'(NUM_REQ);
         end
         w_cand_idx = w_cand[c_IDX_W-1:0];
         if (!w_any && w_nonempty[w_cand_idx]) begin
            w_any   = 1'b1;
            w_grant = w_cand_idx;
         end
      end
   end

   assign w_win     = w_head[w_grant];
   assign w_ovf_evt = |(bus.req_valid & ~w_ready & w_tag_nz);

   // Registered broadcast: flush kills it, hold freezes it, otherwise load the winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cdb_valid  <= 1'b0;
         r_cdb_tag    <= '0;
         r_cdb_value  <= '0;
         r_cdb_src    <= '0;
         r_last_grant <= c_IDX_W'(NUM_REQ - 1);
      end else if (bus.flush) begin
         r_cdb_valid  <= 1'b0;
      end else if (!bus.cdb_hold) begin
         if (w_any) begin
            r_cdb_valid  <= 1'b1;
            r_cdb_tag    <= w_win[c_ENT_W-1 -: TAG_W];
            r_cdb_value  <= w_win[DATA_W-1:0];
            r_cdb_src    <= 2'(w_grant);
            r_last_grant <= w_grant;
         end else begin
            r_cdb_valid  <= 1'b0;
         end
      end
   end

   // Sticky flag for any tagged push that arrived while its FIFO was full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (!bus.flush && w_ovf_evt) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.cdb_valid = r_cdb_valid;
   assign bus.cdb_tag   = r_cdb_tag;
   assign bus.cdb_value = r_cdb_value;
   assign bus.cdb_src   = r_cdb_src;
   assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed and randomized stimulus for cdb_arbiter, checked against
//            a queue-based reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
   localparam int NR    = 3;
   localparam int TW    = 3;
   localparam int DW    = 32;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] val;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_REQ(NR), .TAG_W(TW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model state
   ent_t          mq [NR][$];
   int            m_last;
   logic          m_valid;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_val;
   logic [1:0]    m_src;
   logic          m_ovf;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NR; i++) mq[i].delete();
      m_last  = NR - 1;
      m_valid = 1'b0;
      m_tag   = '0;
      m_val   = '0;
      m_src   = '0;
      m_ovf   = 1'b0;
   endtask

   // Drive one cycle of inputs, check readiness before the edge, advance the
   // model by the behavioural rules, then check all broadcast outputs.
   task automatic cycle(input logic fl, input logic hd, input logic [NR-1:0] v,
                        input logic [NR*TW-1:0] tags, input logic [NR*DW-1:0] vals);
      int            pre [NR];
      int            w;
      int            c;
      ent_t          e;
      logic [NR-1:0] exp_rdy;
      bus.flush     = fl;
      bus.cdb_hold  = hd;
      bus.req_valid = v;
      bus.req_tag   = tags;
      bus.req_value = vals;
      #1;
      for (int i = 0; i < NR; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (fl) begin
         for (int i = 0; i < NR; i++) mq[i].delete();
         m_valid = 1'b0;
      end else begin
         for (int i = 0; i < NR; i++) pre[i] = mq[i].size();
         if (!hd) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
               c = (m_last + k) % NR;
               if (w < 0 && pre[c] > 0) w = c;
            end
            if (w >= 0) begin
               e       = mq[w].pop_front();
               m_valid = 1'b1;
               m_tag   = e.tag;
               m_val   = e.val;
               m_src   = 2'(w);
               m_last  = w;
            end else begin
               m_valid = 1'b0;
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (v[i] && tags[i*TW +: TW] != '0) begin
               if (pre[i] < DEPTH) mq[i].push_back('{tag: tags[i*TW +: TW], val: vals[i*DW +: DW]});
               else m_ovf = 1'b1;
            end
         end
      end
      chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
      chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
      chk("cdb_value", 64'(bus.cdb_value), 64'(m_val));
      chk("cdb_src",   64'(bus.cdb_src),   64'(m_src));
      chk("overflow",  64'(bus.overflow),  64'(m_ovf));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic rand_cycle();
      logic [NR*TW-1:0] t;
      logic [NR*DW-1:0] d;
      for (int i = 0; i < NR; i++) begin
         t[i*TW +: TW] = TW'($urandom_range(0, 7));
         d[i*DW +: DW] = $urandom;
      end
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, NR'($urandom), t, d);
   endtask

   initial begin
      logic [NR-1:0] v;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.cdb_hold  = 1'b0;
      bus.req_valid = '0;
      bus.req_tag   = '0;
      bus.req_value = '0;
      m_reset();
      #12;
      chk("rst_valid", 64'(bus.cdb_valid), 64'(0));
      chk("rst_tag",   64'(bus.cdb_tag),   64'(0));
      chk("rst_ready", 64'(bus.req_ready), 64'(3'b111));
      chk("rst_ovf",   64'(bus.overflow),  64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Single push on requester 0: one-cycle latency, one-cycle pulse
      cycle(1'b0, 1'b0, 3'b001, {6'd0, 3'd3}, {64'd0, 32'h1234});
      chk("t2_no_bypass", 64'(bus.cdb_valid), 64'(0));
      idle(1);
      chk("t2_valid", 64'(bus.cdb_valid), 64'(1));
      chk("t2_tag",   64'(bus.cdb_tag),   64'(3));
      chk("t2_value", 64'(bus.cdb_value), 64'(32'h1234));
      chk("t2_src",   64'(bus.cdb_src),   64'(0));
      idle(1);
      chk("t2_pulse", 64'(bus.cdb_valid), 64'(0));

      // All three requesters push while respecting ready
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < NR; i++) v[i] = (mq[i].size() < DEPTH);
         cycle(1'b0, 1'b0, v, {3'd3, 3'd2, 3'd1}, {$urandom, $urandom, $urandom});
      end
      idle(8);

      // Fill requester 1 under hold, then overflow on the third push
      cycle(1'b0, 1'b1, 3'b010, {3'd0, 3'd4, 3'd0}, {32'd0, 32'hA1, 32'd0});
      cycle(1'b0, 1'b1, 3'b010, {3'd0, 3'd5, 3'd0}, {32'd0, 32'hA2, 32'd0});
      cycle(1'b0, 1'b1, 3'b010, {3'd0, 3'd6, 3'd0}, {32'd0, 32'hA3, 32'd0});
      chk("t4_ovf", 64'(bus.overflow), 64'(1));
      idle(1);
      chk("t4_first_src", 64'(bus.cdb_src), 64'(1));
      idle(3);

      // Flush with queued entries, then a tag-0 push must be ignored
      cycle(1'b0, 1'b1, 3'b111, {3'd1, 3'd2, 3'd3}, {32'hC, 32'hB, 32'hA});
      cycle(1'b0, 1'b1, 3'b111, {3'd4, 3'd5, 3'd6}, {32'hF, 32'hE, 32'hD});
      cycle(1'b1, 1'b0, 3'b111, {3'd7, 3'd7, 3'd7}, {32'h1, 32'h2, 32'h3});
      chk("t5_flush_valid", 64'(bus.cdb_valid), 64'(0));
      idle(3);
      cycle(1'b0, 1'b0, 3'b111, '0, {32'h9, 32'h9, 32'h9});
      idle(2);
      chk("t5_tag0_ignored", 64'(bus.cdb_valid), 64'(0));

      // Hold freezes a live broadcast of tag 5
      cycle(1'b0, 1'b0, 3'b100, {3'd5, 3'd0, 3'd0}, {32'h55, 32'd0, 32'd0});
      cycle(1'b0, 1'b0, 3'b001, {3'd0, 3'd0, 3'd6}, {32'd0, 32'd0, 32'h66});
      chk("t6_tag5", 64'(bus.cdb_tag), 64'(5));
      for (int n = 0; n < 3; n++) begin
         cycle(1'b0, 1'b1, '0, '0, '0);
         chk("t6_frozen_tag", 64'(bus.cdb_tag), 64'(5));
      end
      idle(1);
      chk("t6_next_tag", 64'(bus.cdb_tag), 64'(6));
      chk("t6_next_src", 64'(bus.cdb_src), 64'(0));
      idle(2);

      // Randomized traffic
      for (int n = 0; n < 300; n++) rand_cycle();

      // Asynchronous reset in the middle of traffic
      cycle(1'b0, 1'b1, 3'b111, {3'd1, 3'd2, 3'd3}, {32'h1, 32'h2, 32'h3});
      cycle(1'b0, 1'b0, 3'b111, {3'd4, 3'd5, 3'd6}, {32'h4, 32'h5, 32'h6});
      #2;
      rst = 1'b1;
      #1;
      chk("t1_valid", 64'(bus.cdb_valid), 64'(0));
      chk("t1_tag",   64'(bus.cdb_tag),   64'(0));
      chk("t1_ready", 64'(bus.req_ready), 64'(3'b111));
      chk("t1_ovf",   64'(bus.overflow),  64'(0));
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 40; n++) rand_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
